// File: rtl/gray_counter_bank.sv
// gray_counter_bank: NCHAN binary/gray counters with step, wrap/saturate, sticky flags and a one-entry read-response buffer
module gray_counter_bank #(
  parameter int WIDTH = 4,
  parameter int NCHAN = 4,
  parameter int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  parameter int unsigned STEP = 1,
  parameter bit SATURATE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              increment__ENA,
  input  logic [CHAN_W-1:0] increment_chan,
  output logic              increment__RDY,
  input  logic              decrement__ENA,
  input  logic [CHAN_W-1:0] decrement_chan,
  output logic              decrement__RDY,
  input  logic              writeBin__ENA,
  input  logic [CHAN_W-1:0] writeBin_chan,
  input  logic [WIDTH-1:0]  writeBin_v,
  output logic              writeBin__RDY,
  input  logic              writeGray__ENA,
  input  logic [CHAN_W-1:0] writeGray_chan,
  input  logic [WIDTH-1:0]  writeGray_v,
  output logic              writeGray__RDY,
  input  logic              read__ENA,
  input  logic [CHAN_W-1:0] read_chan,
  output logic              read__RDY,
  output logic              rsp__ENA,
  output logic [WIDTH-1:0]  rsp_bin,
  output logic [WIDTH-1:0]  rsp_gray,
  output logic              rsp_flag,
  input  logic              rsp__RDY
);
  localparam logic [WIDTH:0] STEP_V = (WIDTH+1)'(STEP);
  logic [WIDTH-1:0] r_bin [NCHAN];
  logic [NCHAN-1:0] r_flag;
  logic [WIDTH-1:0] w_bin_nxt [NCHAN];
  logic [NCHAN-1:0] w_flag_nxt;
  logic [WIDTH-1:0] w_gbin, w_rd_bin, r_rsp_bin;
  logic             w_rd, w_rd_flag, r_rsp_ena, r_rsp_flag;
  assign increment__RDY = !RST;
  assign decrement__RDY = !RST;
  assign writeBin__RDY  = !RST;
  assign writeGray__RDY = !RST;
  assign read__RDY      = !RST && (!r_rsp_ena || rsp__RDY);
  assign w_rd           = read__ENA && read__RDY;
  assign rsp__ENA       = r_rsp_ena;
  assign rsp_bin        = r_rsp_bin;
  assign rsp_gray       = r_rsp_bin ^ (r_rsp_bin >> 1);
  assign rsp_flag       = r_rsp_flag;
  always_comb begin
    w_gbin = '0;
    for (int i = 0; i < WIDTH; i++) w_gbin[i] = ^(writeGray_v >> i);
  end
  always_comb begin
    w_rd_bin  = '0;
    w_rd_flag = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin
      w_rd_bin  = (32'(read_chan) == c) ? r_bin[c] : w_rd_bin;
      w_rd_flag = (32'(read_chan) == c) ? r_flag[c] : w_rd_flag;
    end
  end
  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic             w_inc, w_dec, w_wb, w_wg, w_clr, w_evt;
    logic [WIDTH:0]   w_sum, w_dif;
    assign w_inc = increment__ENA && increment__RDY && 32'(increment_chan) == c;
    assign w_dec = decrement__ENA && decrement__RDY && 32'(decrement_chan) == c;
    assign w_wb  = writeBin__ENA && writeBin__RDY && 32'(writeBin_chan) == c;
    assign w_wg  = writeGray__ENA && writeGray__RDY && 32'(writeGray_chan) == c;
    assign w_clr = w_rd && 32'(read_chan) == c;
    assign w_sum = {1'b0, r_bin[c]} + STEP_V;
    assign w_dif = {1'b0, r_bin[c]} - STEP_V;
    assign w_evt = !w_wb && !w_wg && ((w_inc && !w_dec && w_sum[WIDTH]) || (w_dec && !w_inc && w_dif[WIDTH]));
    assign w_bin_nxt[c] = w_wb ? writeBin_v :
                          w_wg ? w_gbin :
                          (w_inc && !w_dec) ? ((SATURATE && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0]) :
                          (w_dec && !w_inc) ? ((SATURATE && w_dif[WIDTH]) ? '0 : w_dif[WIDTH-1:0]) :
                          r_bin[c];
    assign w_flag_nxt[c] = w_evt || (r_flag[c] && !w_clr);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < NCHAN; c++) r_bin[c] <= '0;
      r_flag     <= '0;
      r_rsp_ena  <= 1'b0;
      r_rsp_bin  <= '0;
      r_rsp_flag <= 1'b0;
    end else begin
      for (int c = 0; c < NCHAN; c++) r_bin[c] <= w_bin_nxt[c];
      r_flag    <= w_flag_nxt;
      r_rsp_ena <= w_rd || (r_rsp_ena && !rsp__RDY);
      if (w_rd) begin
        r_rsp_bin  <= w_rd_bin;
        r_rsp_flag <= w_rd_flag;
      end
    end
  end
endmodule

// File: tb/tb_gray_counter_bank.sv
// tb_gray_counter_bank: scoreboard bench for a wrapping bank and a saturating, step-3, 3-channel bank
module tb_gray_counter_bank;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  logic [8:0] q_a[$], q_b[$];
  logic       a_inc_en = 0, a_dec_en = 0, a_wb_en = 0, a_wg_en = 0, a_rd_en = 0, a_rsp_rdy = 1;
  logic [1:0] a_inc_ch = 0, a_dec_ch = 0, a_wb_ch = 0, a_wg_ch = 0, a_rd_ch = 0;
  logic [3:0] a_wb_v = 0, a_wg_v = 0;
  logic       a_inc_rdy, a_dec_rdy, a_wb_rdy, a_wg_rdy, a_rd_rdy, a_rsp_en, a_rsp_flag;
  logic [3:0] a_rsp_bin, a_rsp_gray;
  logic       b_inc_en = 0, b_dec_en = 0, b_wb_en = 0, b_wg_en = 0, b_rd_en = 0, b_rsp_rdy = 1;
  logic [1:0] b_inc_ch = 0, b_dec_ch = 0, b_wb_ch = 0, b_wg_ch = 0, b_rd_ch = 0;
  logic [3:0] b_wb_v = 0, b_wg_v = 0;
  logic       b_inc_rdy, b_dec_rdy, b_wb_rdy, b_wg_rdy, b_rd_rdy, b_rsp_en, b_rsp_flag;
  logic [3:0] b_rsp_bin, b_rsp_gray;
  gray_counter_bank u_a (
    .CLK(clk), .RST(rst),
    .increment__ENA(a_inc_en), .increment_chan(a_inc_ch), .increment__RDY(a_inc_rdy),
    .decrement__ENA(a_dec_en), .decrement_chan(a_dec_ch), .decrement__RDY(a_dec_rdy),
    .writeBin__ENA(a_wb_en), .writeBin_chan(a_wb_ch), .writeBin_v(a_wb_v), .writeBin__RDY(a_wb_rdy),
    .writeGray__ENA(a_wg_en), .writeGray_chan(a_wg_ch), .writeGray_v(a_wg_v), .writeGray__RDY(a_wg_rdy),
    .read__ENA(a_rd_en), .read_chan(a_rd_ch), .read__RDY(a_rd_rdy),
    .rsp__ENA(a_rsp_en), .rsp_bin(a_rsp_bin), .rsp_gray(a_rsp_gray), .rsp_flag(a_rsp_flag), .rsp__RDY(a_rsp_rdy)
  );
  gray_counter_bank #(.NCHAN(3), .STEP(3), .SATURATE(1)) u_b (
    .CLK(clk), .RST(rst),
    .increment__ENA(b_inc_en), .increment_chan(b_inc_ch), .increment__RDY(b_inc_rdy),
    .decrement__ENA(b_dec_en), .decrement_chan(b_dec_ch), .decrement__RDY(b_dec_rdy),
    .writeBin__ENA(b_wb_en), .writeBin_chan(b_wb_ch), .writeBin_v(b_wb_v), .writeBin__RDY(b_wb_rdy),
    .writeGray__ENA(b_wg_en), .writeGray_chan(b_wg_ch), .writeGray_v(b_wg_v), .writeGray__RDY(b_wg_rdy),
    .read__ENA(b_rd_en), .read_chan(b_rd_ch), .read__RDY(b_rd_rdy),
    .rsp__ENA(b_rsp_en), .rsp_bin(b_rsp_bin), .rsp_gray(b_rsp_gray), .rsp_flag(b_rsp_flag), .rsp__RDY(b_rsp_rdy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && a_rsp_en && a_rsp_rdy) begin
      if (q_a.size() == 0) chk("a_rsp_unexpected", 1, 0);
      else chk("a_rsp", {a_rsp_bin, a_rsp_gray, a_rsp_flag}, q_a.pop_front());
    end
    if (!rst && b_rsp_en && b_rsp_rdy) begin
      if (q_b.size() == 0) chk("b_rsp_unexpected", 1, 0);
      else chk("b_rsp", {b_rsp_bin, b_rsp_gray, b_rsp_flag}, q_b.pop_front());
    end
  end
  task automatic rd_a(input logic [1:0] ch, input logic [3:0] b, input logic [3:0] g, input logic f);
    int k = 0;
    while (!a_rd_rdy && k < 20) begin cyc(); k++; end
    chk("a_rd_rdy_wait", a_rd_rdy, 1);
    a_rd_en = 1; a_rd_ch = ch; q_a.push_back({b, g, f});
    cyc();
    a_rd_en = 0;
  endtask
  task automatic rd_b(input logic [1:0] ch, input logic [3:0] b, input logic [3:0] g, input logic f);
    int k = 0;
    while (!b_rd_rdy && k < 20) begin cyc(); k++; end
    chk("b_rd_rdy_wait", b_rd_rdy, 1);
    b_rd_en = 1; b_rd_ch = ch; q_b.push_back({b, g, f});
    cyc();
    b_rd_en = 0;
  endtask
  task automatic wb_a(input logic [1:0] ch, input logic [3:0] v);
    a_wb_en = 1; a_wb_ch = ch; a_wb_v = v;
    cyc();
    a_wb_en = 0;
  endtask
  task automatic wb_b(input logic [1:0] ch, input logic [3:0] v);
    b_wb_en = 1; b_wb_ch = ch; b_wb_v = v;
    cyc();
    b_wb_en = 0;
  endtask
  initial begin
    cyc(); cyc();
    chk("rst_a_rsp_en", a_rsp_en, 0);
    chk("rst_a_inc_rdy", a_inc_rdy, 0);
    chk("rst_a_rd_rdy", a_rd_rdy, 0);
    chk("rst_b_rd_rdy", b_rd_rdy, 0);
    chk("rst_a_rsp_bin", a_rsp_bin, 0);
    rst = 0;
    #1;
    chk("a_inc_rdy", a_inc_rdy, 1);
    chk("a_wg_rdy", a_wg_rdy, 1);
    chk("a_rd_rdy", a_rd_rdy, 1);
    rd_a(0, 0, 0, 0);
    a_inc_en = 1; a_inc_ch = 2;
    repeat (16) cyc();
    a_inc_en = 0;
    rd_a(2, 0, 0, 1);
    rd_a(2, 0, 0, 0);
    a_wg_en = 1; a_wg_ch = 3; a_wg_v = 4'b1101;
    cyc();
    a_wg_en = 0;
    rd_a(3, 9, 13, 0);
    wb_a(0, 5);
    a_inc_en = 1; a_inc_ch = 0; a_dec_en = 1; a_dec_ch = 0;
    a_rd_en = 1; a_rd_ch = 0; q_a.push_back({4'd5, 4'd7, 1'b0});
    cyc();
    a_inc_en = 0; a_dec_en = 0; a_rd_en = 0;
    rd_a(0, 5, 7, 0);
    a_wb_en = 1; a_wb_ch = 0; a_wb_v = 7; a_inc_en = 1; a_inc_ch = 0;
    cyc();
    a_wb_en = 0; a_inc_en = 0;
    rd_a(0, 7, 4, 0);
    wb_a(2, 11);
    a_rsp_rdy = 0;
    rd_a(0, 7, 4, 0);
    a_rd_en = 1; a_rd_ch = 2;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rd_rdy", a_rd_rdy, 0);
      chk("bp_rsp_en", a_rsp_en, 1);
      chk("bp_rsp_bin", a_rsp_bin, 7);
      chk("bp_rsp_gray", a_rsp_gray, 4);
      cyc();
    end
    a_rsp_rdy = 1; q_a.push_back({4'd11, 4'd14, 1'b0});
    #1;
    chk("bp_release_rd_rdy", a_rd_rdy, 1);
    cyc();
    a_rd_en = 0;
    cyc();
    chk("bp_rsp_drop", a_rsp_en, 0);
    wb_b(1, 14);
    b_inc_en = 1; b_inc_ch = 1;
    cyc();
    b_inc_en = 0;
    rd_b(1, 15, 8, 1);
    wb_b(1, 1);
    b_dec_en = 1; b_dec_ch = 1;
    cyc();
    b_dec_en = 0;
    rd_b(1, 0, 0, 1);
    wb_b(3, 9);
    rd_b(3, 0, 0, 0);
    rd_b(0, 0, 0, 0);
    wb_b(2, 14);
    b_inc_en = 1; b_inc_ch = 2;
    b_rd_en = 1; b_rd_ch = 2; q_b.push_back({4'd14, 4'd9, 1'b0});
    cyc();
    b_inc_en = 0; b_rd_en = 0;
    rd_b(2, 15, 8, 1);
    cyc();
    a_rsp_rdy = 0;
    rd_a(2, 11, 14, 0);
    rst = 1;
    cyc();
    chk("midrst_rsp_en", a_rsp_en, 0);
    chk("midrst_rd_rdy", a_rd_rdy, 0);
    q_a.delete();
    rst = 0; a_rsp_rdy = 1;
    rd_a(2, 0, 0, 0);
    rd_a(0, 0, 0, 0);
    rd_b(2, 0, 0, 0);
    cyc(); cyc();
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
